// File: rtl/pll_seq_pkg.sv
// Shared state type and default configuration for the PLL lock sequencer.
// Optional feature macro: PLL_SEQ_WATCHDOG_EN adds the relock timer and PLLRST state.
package pll_seq_pkg;

  localparam int unsigned LOCK_FILTER_DEF    = 1024;
  localparam int unsigned RELOCK_TIMEOUT_DEF = 65536;
  localparam int unsigned PLLRST_CYCLES_DEF  = 16;
  localparam int unsigned NSTAGES_DEF        = 4;
  localparam int unsigned STAGE_GAP_DEF      = 8;

  localparam int unsigned RELOCK_W = 8;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
`ifdef PLL_SEQ_WATCHDOG_EN
    PLLRST    = 3'd1,
`endif
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // Saturating increment for the lock-loss counter.
  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (v == '1) ? v : v + RELOCK_W'(1);
  endfunction

endpackage

// File: rtl/pll_seq_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module pll_seq_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Double-register the input; reset clears both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: filters the synchronized lock, then releases staged resets.
// Optional feature macro: PLL_SEQ_WATCHDOG_EN enables the relock timeout, the
// PLLRST state and the pll_rst pulse; without it pll_rst is tied low and
// WAIT_LOCK waits indefinitely.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOCK_FILTER    = LOCK_FILTER_DEF,
  parameter int unsigned RELOCK_TIMEOUT = RELOCK_TIMEOUT_DEF,
  parameter int unsigned PLLRST_CYCLES  = PLLRST_CYCLES_DEF,
  parameter int unsigned NSTAGES        = NSTAGES_DEF,
  parameter int unsigned STAGE_GAP      = STAGE_GAP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  output logic                pll_rst,
  output logic [NSTAGES-1:0]  stage_rst,
  output logic                ready,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int unsigned RELEASE_LEN = STAGE_GAP * NSTAGES;
  localparam int unsigned FW          = $clog2(LOCK_FILTER) + 1;
  localparam int unsigned RW          = $clog2(RELEASE_LEN) + 1;

  // Reject configurations the counters cannot represent.
  if (LOCK_FILTER == 0 || NSTAGES == 0 || STAGE_GAP == 0 ||
      RELOCK_TIMEOUT < 2 || PLLRST_CYCLES == 0) begin : g_cfg_check
    $error("pll_lock_sequencer: invalid parameter set");
  end

  state_t              state;
  state_t              state_nx;
  logic [FW-1:0]       flt_cnt;
  logic [FW-1:0]       flt_nx;
  logic [RW-1:0]       rel_cnt;
  logic [RW-1:0]       rel_nx;
  logic [RELOCK_W-1:0] relock_nx;
  logic [NSTAGES-1:0]  stage_rst_d;
  logic                ready_d;
  logic                lock_s;

`ifdef PLL_SEQ_WATCHDOG_EN
  localparam int unsigned TW = $clog2(RELOCK_TIMEOUT) + 1;
  localparam int unsigned PW = $clog2(PLLRST_CYCLES) + 1;

  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_nx;
  logic [PW-1:0] prc;
  logic [PW-1:0] prc_nx;
  logic          pll_rst_d;
`endif

  // Lock input synchronizer; every decision below uses lock_s only.
  pll_seq_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pll_locked),
    .sync_out (lock_s)
  );

  // State register and sequencing counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_LOCK;
      flt_cnt <= '0;
      rel_cnt <= '0;
`ifdef PLL_SEQ_WATCHDOG_EN
      tmr     <= '0;
      prc     <= '0;
`endif
    end else begin
      state   <= state_nx;
      flt_cnt <= flt_nx;
      rel_cnt <= rel_nx;
`ifdef PLL_SEQ_WATCHDOG_EN
      tmr     <= tmr_nx;
      prc     <= prc_nx;
`endif
    end
  end

  // Next-state, counter and lock-loss bookkeeping.
  always_comb begin
    state_nx  = state;
    flt_nx    = '0;
    rel_nx    = '0;
    relock_nx = relock_cnt;
`ifdef PLL_SEQ_WATCHDOG_EN
    tmr_nx    = '0;
    prc_nx    = '0;
`endif
    case (state)
      WAIT_LOCK: begin
        // A lock seen in the same cycle as the timeout takes priority.
        if (lock_s) begin
          state_nx = FILTER;
          flt_nx   = FW'(1);
        end
`ifdef PLL_SEQ_WATCHDOG_EN
        else if (tmr == TW'(RELOCK_TIMEOUT - 1)) begin
          state_nx = PLLRST;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
`endif
      end
`ifdef PLL_SEQ_WATCHDOG_EN
      PLLRST: begin
        // Lock is deliberately ignored while the PLL is held in reset.
        if (prc == PW'(PLLRST_CYCLES - 1)) begin
          state_nx = WAIT_LOCK;
        end else begin
          prc_nx = prc + PW'(1);
        end
      end
`endif
      FILTER: begin
        // A dropout here is a glitch, not a lock loss: no relock count.
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
        end else if (flt_cnt >= FW'(LOCK_FILTER - 1)) begin
          state_nx = RELEASE;
        end else begin
          flt_nx = flt_cnt + FW'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_nx  = WAIT_LOCK;
          relock_nx = sat_inc(relock_cnt);
        end else if (rel_cnt == RW'(RELEASE_LEN)) begin
          state_nx = RUN;
        end else begin
          rel_nx = rel_cnt + RW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nx  = WAIT_LOCK;
          relock_nx = sat_inc(relock_cnt);
        end
      end
      default: begin
        state_nx = WAIT_LOCK;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs register cleanly.
  always_comb begin
    stage_rst_d = '1;
    ready_d     = 1'b0;
`ifdef PLL_SEQ_WATCHDOG_EN
    pll_rst_d   = 1'b0;
`endif
    case (state_nx)
      RELEASE: begin
        // Stage i drops once STAGE_GAP*(i+1) cycles have elapsed in RELEASE.
        for (int unsigned i = 0; i < NSTAGES; i++) begin
          stage_rst_d[i] = (rel_nx < RW'(STAGE_GAP * (i + 1)));
        end
      end
      RUN: begin
        stage_rst_d = '0;
        ready_d     = 1'b1;
      end
`ifdef PLL_SEQ_WATCHDOG_EN
      PLLRST: begin
        pll_rst_d = 1'b1;
      end
`endif
      default: begin
        stage_rst_d = '1;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_rst  <= '1;
      ready      <= 1'b0;
      relock_cnt <= '0;
`ifdef PLL_SEQ_WATCHDOG_EN
      pll_rst    <= 1'b0;
`endif
    end else begin
      stage_rst  <= stage_rst_d;
      ready      <= ready_d;
      relock_cnt <= relock_nx;
`ifdef PLL_SEQ_WATCHDOG_EN
      pll_rst    <= pll_rst_d;
`endif
    end
  end

`ifndef PLL_SEQ_WATCHDOG_EN
  assign pll_rst = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer (scoreboard of per-cycle expectations).
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic [3:0] stage_rst;
  logic       ready;
  logic [7:0] relock_cnt;

  typedef struct packed {
    logic [3:0] stage;
    logic       rdy;
    logic       prst;
    logic [7:0] relock;
  } obs_t;

  obs_t obs_now;
  obs_t exp_v;
  obs_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  assign obs_now = {stage_rst, ready, pll_rst, relock_cnt};

  pll_lock_sequencer #(
    .LOCK_FILTER    (8),
    .RELOCK_TIMEOUT (32),
    .PLLRST_CYCLES  (4),
    .NSTAGES        (4),
    .STAGE_GAP      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .stage_rst  (stage_rst),
    .ready      (ready),
    .relock_cnt (relock_cnt)
  );

  function automatic obs_t mk(input logic [3:0] s, input logic r, input logic p, input logic [7:0] k);
    return {s, r, p, k};
  endfunction

  // Expected stage resets for a RELEASE entered at cycle 'entry' with gap 2.
  function automatic logic [3:0] rel_mask(input int c, input int entry);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (c < entry + 2 * (i + 1));
    return m;
  endfunction

  task automatic apply_reset(input logic lk);
    rst        = 1'b1;
    pll_locked = lk;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    pll_locked = 1'b1;
    for (int c = 0; c < 4; c++) exp_q.push_back(mk(4'hF, 1'b0, 1'b0, 8'd0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs_now !== exp_v) begin
        n_fail++;
        $display("FAIL reset c=%0d got stage=%b ready=%b pll_rst=%b relock=%0d want stage=%b ready=%b pll_rst=%b relock=%0d",
                 c, obs_now.stage, obs_now.rdy, obs_now.prst, obs_now.relock,
                 exp_v.stage, exp_v.rdy, exp_v.prst, exp_v.relock);
      end
    end
  endtask

  task automatic test_clean_lock();
    apply_reset(1'b0);
    for (int c = 0; c <= 22; c++) exp_q.push_back(mk(rel_mask(c, 10), c >= 19, 1'b0, 8'd0));
    for (int c = 0; c <= 22; c++) begin
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs_now !== exp_v) begin
        n_fail++;
        $display("FAIL clean_lock c=%0d got stage=%b ready=%b pll_rst=%b relock=%0d want stage=%b ready=%b pll_rst=%b relock=%0d",
                 c, obs_now.stage, obs_now.rdy, obs_now.prst, obs_now.relock,
                 exp_v.stage, exp_v.rdy, exp_v.prst, exp_v.relock);
      end
      if (c == 0) begin
        rst        = 1'b0;
        pll_locked = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock_loss();
    for (int c = 0; c <= 5; c++)
      exp_q.push_back((c < 3) ? mk(4'h0, 1'b1, 1'b0, 8'd0) : mk(4'hF, 1'b0, 1'b0, 8'd1));
    for (int c = 0; c <= 5; c++) begin
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs_now !== exp_v) begin
        n_fail++;
        $display("FAIL lock_loss c=%0d got stage=%b ready=%b pll_rst=%b relock=%0d want stage=%b ready=%b pll_rst=%b relock=%0d",
                 c, obs_now.stage, obs_now.rdy, obs_now.prst, obs_now.relock,
                 exp_v.stage, exp_v.rdy, exp_v.prst, exp_v.relock);
      end
      if (c == 0) pll_locked = 1'b0;
      @(negedge clk);
    end
  endtask

  // Each pass reaches RELEASE then drops lock: one counted loss per pass.
  task automatic test_relock_saturation();
    for (int n = 2; n <= 300; n++) begin
      exp_q.push_back(mk(4'hF, 1'b0, 1'b0, (n > 255) ? 8'd255 : 8'(n)));
      pll_locked = 1'b1;
      repeat (10) @(negedge clk);
      pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs_now !== exp_v) begin
        n_fail++;
        $display("FAIL relock_sat loss=%0d got stage=%b ready=%b pll_rst=%b relock=%0d want stage=%b ready=%b pll_rst=%b relock=%0d",
                 n, obs_now.stage, obs_now.rdy, obs_now.prst, obs_now.relock,
                 exp_v.stage, exp_v.rdy, exp_v.prst, exp_v.relock);
      end
    end
  endtask

  task automatic test_rst_mid_release();
    for (int c = 0; c <= 15; c++)
      exp_q.push_back((c < 15) ? mk(rel_mask(c, 10), 1'b0, 1'b0, 8'd255) : mk(4'hF, 1'b0, 1'b0, 8'd0));
    for (int c = 0; c <= 15; c++) begin
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs_now !== exp_v) begin
        n_fail++;
        $display("FAIL rst_mid_release c=%0d got stage=%b ready=%b pll_rst=%b relock=%0d want stage=%b ready=%b pll_rst=%b relock=%0d",
                 c, obs_now.stage, obs_now.rdy, obs_now.prst, obs_now.relock,
                 exp_v.stage, exp_v.rdy, exp_v.prst, exp_v.relock);
      end
      if (c == 0)  pll_locked = 1'b1;
      if (c == 14) rst = 1'b1;
      @(negedge clk);
    end
  endtask

  // Five lock cycles then a three-cycle dropout: the filter must restart.
  task automatic test_glitch();
    apply_reset(1'b0);
    for (int c = 0; c <= 22; c++) exp_q.push_back(mk(rel_mask(c, 18), 1'b0, 1'b0, 8'd0));
    for (int c = 0; c <= 22; c++) begin
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs_now !== exp_v) begin
        n_fail++;
        $display("FAIL glitch c=%0d got stage=%b ready=%b pll_rst=%b relock=%0d want stage=%b ready=%b pll_rst=%b relock=%0d",
                 c, obs_now.stage, obs_now.rdy, obs_now.prst, obs_now.relock,
                 exp_v.stage, exp_v.rdy, exp_v.prst, exp_v.relock);
      end
      if (c == 0) begin
        rst        = 1'b0;
        pll_locked = 1'b1;
      end
      if (c == 5) pll_locked = 1'b0;
      if (c == 8) pll_locked = 1'b1;
      @(negedge clk);
    end
  endtask

  // Lock never arrives; reset is reapplied in the middle of the third pulse.
  task automatic test_watchdog();
    logic p;
    apply_reset(1'b0);
    for (int c = 0; c <= 106; c++) begin
`ifdef PLL_SEQ_WATCHDOG_EN
      p = (c >= 32) && (c <= 105) && (((c - 32) % 36) < 4);
`else
      p = 1'b0;
`endif
      exp_q.push_back(mk(4'hF, 1'b0, p, 8'd0));
    end
    for (int c = 0; c <= 106; c++) begin
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs_now !== exp_v) begin
        n_fail++;
        $display("FAIL watchdog c=%0d got stage=%b ready=%b pll_rst=%b relock=%0d want stage=%b ready=%b pll_rst=%b relock=%0d",
                 c, obs_now.stage, obs_now.rdy, obs_now.prst, obs_now.relock,
                 exp_v.stage, exp_v.rdy, exp_v.prst, exp_v.relock);
      end
      if (c == 0)   rst = 1'b0;
      if (c == 105) rst = 1'b1;
      if (c == 106) rst = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    test_clean_lock();
    test_lock_loss();
    test_relock_saturation();
    test_rst_mid_release();
    test_glitch();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
